// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional leading-zero early-out is enabled by defining DIV_EARLY_OUT_EN.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            FlushE,
    input  logic            DivStartE,
    input  logic            DivControlE,
    input  logic            RemE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic [XLEN-1:0] DivResultE,
    output logic            DivBusy,
    output logic            DivDone
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] wr_q, wr_d;
    logic [XLEN-1:0] hq_q, hq_d;
    logic [XLEN-1:0] hr_q, hr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ctl_q, ctl_d;
    logic            sq_q, sq_d;
    logic            sr_q, sr_d;

    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   rsh, diff;
    logic [XLEN-1:0] step_q, step_r;
    logic [XLEN-1:0] wq_init;
    logic [CW-1:0]   n_init;
    logic            ovf;

`ifdef DIV_EARLY_OUT_EN
    logic [CW-1:0]   lz;

    function automatic logic [CW-1:0] lzc(input logic [XLEN-1:0] v);
        lzc = CW'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (v[i]) lzc = CW'(XLEN - 1 - i);
        end
    endfunction
`endif

    // Operand magnitudes, one restoring step, and the PREP loop setup
    always_comb begin
        neg_a = ctl_q & opa_q[XLEN-1];
        neg_b = ctl_q & opb_q[XLEN-1];
        mag_a = neg_a ? (~opa_q + 1'b1) : opa_q;
        mag_b = neg_b ? (~opb_q + 1'b1) : opb_q;
        ovf   = ctl_q
              & (opa_q == {1'b1, {(XLEN-1){1'b0}}})
              & (&opb_q);
        rsh   = {wr_q, opa_q[XLEN-1]};
        diff  = rsh - {1'b0, opb_q};
        if (!diff[XLEN]) begin
            step_r = diff[XLEN-1:0];
            step_q = {opa_q[XLEN-2:0], 1'b1};
        end else begin
            step_r = rsh[XLEN-1:0];
            step_q = {opa_q[XLEN-2:0], 1'b0};
        end
`ifdef DIV_EARLY_OUT_EN
        lz      = lzc(mag_a);
        n_init  = CW'(XLEN) - lz;
        if (n_init == '0) n_init = CW'(1);
        wq_init = mag_a << lz;
`else
        n_init  = CW'(XLEN);
        wq_init = mag_a;
`endif
    end

    // Next-state and datapath updates; flush overrides everything
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        wr_d    = wr_q;
        hq_d    = hq_q;
        hr_d    = hr_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        if (FlushE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (DivStartE) begin
                        state_d = PREP;
                        opa_d   = SrcAE;
                        opb_d   = SrcBE;
                        ctl_d   = DivControlE;
                    end
                end
                PREP: begin
                    sq_d  = neg_a ^ neg_b;
                    sr_d  = neg_a;
                    cnt_d = n_init;
                    if (opb_q == '0) begin
                        hq_d    = '1;
                        hr_d    = opa_q;
                        state_d = DONE;
                    end else if (ovf) begin
                        hq_d    = opa_q;
                        hr_d    = '0;
                        state_d = DONE;
                    end else begin
                        opa_d   = wq_init;
                        opb_d   = mag_b;
                        wr_d    = '0;
                        state_d = (n_init == CW'(1)) ? FIX : RUN;
                    end
                end
                RUN: begin
                    opa_d = step_q;
                    wr_d  = step_r;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(2)) state_d = FIX;
                end
                FIX: begin
                    // Final iteration folded in with the sign fix-up
                    cnt_d   = '0;
                    opa_d   = step_q;
                    wr_d    = step_r;
                    hq_d    = sq_q ? (~step_q + 1'b1) : step_q;
                    hr_d    = sr_q ? (~step_r + 1'b1) : step_r;
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            wr_q    <= '0;
            hq_q    <= '0;
            hr_q    <= '0;
            cnt_q   <= '0;
            ctl_q   <= 1'b0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            wr_q    <= wr_d;
            hq_q    <= hq_d;
            hr_q    <= hr_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
        end
    end

    assign DivBusy    = (state_q == PREP) | (state_q == RUN) | (state_q == FIX);
    assign DivDone    = (state_q == DONE);
    assign DivResultE = RemE ? hr_q : hq_q;

endmodule
